// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory responder and the core's load path.
//   - RV32I funct3 access-width encodings (F3_*)
//   - state_t : responder FSM states
//   - load_extend() : aligns a loaded byte/half to bit 0 and extends it
// No ports (package).
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Shift the addressed byte or halfword down to bit 0, then sign- or
    // zero-extend according to the width. Illegal widths yield zero.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  funct3);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {24'h0, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {16'h0, shifted[15:0]};
            F3_W:    result = word;
            default: result = 32'h0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// ---------------------------------------------------------------------------
// byte_lane_ram
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a
// registered read. No reset: contents survive a responder reset.
// Ports:
//   clk_i   : clock
//   en_i    : port enable; a read (and optional write) happens on this edge
//   be_i    : byte-lane write enables, bit n writes wdata_i[8n+7:8n]
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : read data, old contents of the word, held while en_i is low
// ---------------------------------------------------------------------------
module byte_lane_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Read-before-write: rdata_o keeps its value between enabled cycles,
    // which lets the responder hold a stable load result during backpressure.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Responder end of the core's load/store data bus. Takes one request at a
// time, waits WAIT_CYCLES, then performs the access on an internal RAM and
// presents a response until the core accepts it. Misaligned, out-of-range
// and illegal-width requests are answered with rsp_err instead of accessing.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   req_valid / req_ready     : request handshake
//   req_we, req_funct3        : store flag and RV32I access width
//   req_addr, req_wdata       : byte address and store data
//   rsp_valid / rsp_ready     : response handshake
//   rsp_rdata, rsp_err        : extended load data (0 for stores/errors), error
// ---------------------------------------------------------------------------
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS * 4);

    state_t      state_q, state_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic        access;
    logic        curWe;
    logic [2:0]  curF3;
    logic [31:0] curAddr;
    logic [31:0] curWdata;
    logic [31:0] curOffset;
    logic        illegalWidth;
    logic        misaligned;
    logic        outOfRange;
    logic        curErr;
    logic [3:0]  byteEn;
    logic [31:0] laneWdata;
    logic        ramEn;
    logic [3:0]  ramBe;
    logic [31:0] ramRdata;

    // The request being served: straight from the bus while IDLE (needed when
    // WAIT_CYCLES is 0 and the access shares the accept edge), else the copy.
    always_comb begin
        curWe    = we_q;
        curF3    = f3_q;
        curAddr  = addr_q;
        curWdata = wdata_q;
        if (state_q == IDLE) begin
            curWe    = req_we;
            curF3    = req_funct3;
            curAddr  = req_addr;
            curWdata = req_wdata;
        end
    end

    // Below-base addresses wrap to a huge offset and fail the range test.
    assign curOffset  = curAddr - ADDR_BASE;
    assign outOfRange = (curOffset >= RANGE_BYTES);

    // Width decode: byte enables, lane-replicated store data, and the
    // alignment/width legality of the request.
    always_comb begin
        illegalWidth = 1'b0;
        misaligned   = 1'b0;
        byteEn       = 4'b0000;
        laneWdata    = curWdata;
        case (curF3)
            F3_B, F3_BU: begin
                byteEn    = 4'b0001 << curOffset[1:0];
                laneWdata = {4{curWdata[7:0]}};
            end
            F3_H, F3_HU: begin
                misaligned = curOffset[0];
                byteEn     = curOffset[1] ? 4'b1100 : 4'b0011;
                laneWdata  = {2{curWdata[15:0]}};
            end
            F3_W: begin
                misaligned = (curOffset[1:0] != 2'b00);
                byteEn     = 4'b1111;
            end
            default: illegalWidth = 1'b1;
        endcase
        if (curWe && ((curF3 == F3_BU) || (curF3 == F3_HU))) begin
            illegalWidth = 1'b1;
        end
    end

    assign curErr = illegalWidth | misaligned | outOfRange;

    // A reset arriving on the access edge must suppress the write.
    assign ramEn = access & rst;
    assign ramBe = (curWe && !curErr) ? byteEn : 4'b0000;

    byte_lane_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk_i  (clk),
        .en_i   (ramEn),
        .be_i   (ramBe),
        .addr_i (curOffset[AW+1:2]),
        .wdata_i(laneWdata),
        .rdata_o(ramRdata)
    );

    // Next-state logic: capture in IDLE, count down in WAIT, hold in RESP
    // until the core takes the response.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        access    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d   = WAIT;
                        waitCnt_d = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (access) begin
            err_d = curErr;
        end
    end

    // State and captured-request registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    // Response data comes from the RAM's output register; it is only shown
    // for successful loads while in RESP, so nothing undefined leaks out.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !we_q)
                       ? load_extend(ramRdata, addr_q[1:0], f3_q) : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder: one instance with the default two
// wait states, one with zero wait states. Each test task drives its own
// vectors and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;
    import mem_pkg::*;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        zReqValid = 1'b0, zReqWe = 1'b0, zRspReady = 1'b0;
    logic [2:0]  zReqF3 = 3'b000;
    logic [31:0] zReqAddr = 32'h0, zReqWdata = 32'h0;
    logic        zReqReady, zRspValid, zRspErr;
    logic [31:0] zRspRdata;

    always #5 clk = ~clk;

    // Edge counter used to time accept edges.
    always @(posedge clk) cyc++;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .ADDR_BASE(32'h0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dutZero (
        .clk(clk), .rst(rst),
        .req_valid(zReqValid), .req_ready(zReqReady), .req_we(zReqWe),
        .req_funct3(zReqF3), .req_addr(zReqAddr), .req_wdata(zReqWdata),
        .rsp_valid(zRspValid), .rsp_ready(zRspReady),
        .rsp_rdata(zRspRdata), .rsp_err(zRspErr)
    );

    // Step to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full request/response on the main instance, starting in IDLE and
    // accepting the response on its first cycle. lat counts cycles from the
    // accept edge to the first rsp_valid cycle.
    task automatic doTxn(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int acceptCyc);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
        tick;
        acceptCyc = cyc;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick;
            lat++;
        end
        if (!rsp_valid) begin
            checks++; failures++;
            $display("[TB] FAIL rsp_timeout addr=%h got no rsp_valid, required within 40 cycles", addr);
        end
        rdata = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick; tick; tick;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (zReqReady !== 1'b1 || zRspValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_zero_wait got ready=%b valid=%b exp ready=1 valid=0", zReqReady, zRspValid); end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_word_access;
        vec_t v[5] = '{
            '{1'b1, F3_W, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, F3_W, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b1, F3_W, 32'h0,   32'h0BADF00D, 32'h0,        1'b0},
            '{1'b1, F3_W, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0},
            '{1'b0, F3_W, 32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0}
        };
        logic [31:0] rd; logic er; int lat, ac;
        for (int i = 0; i < 5; i++) begin
            doTxn(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat, ac);
            checks++; if (rd !== v[i].expData) begin failures++; $display("[TB] FAIL word_rdata[%0d] got=%h exp=%h", i, rd, v[i].expData); end
            checks++; if (er !== v[i].expErr) begin failures++; $display("[TB] FAIL word_err[%0d] got=%b exp=%b", i, er, v[i].expErr); end
            checks++; if (lat != 3) begin failures++; $display("[TB] FAIL word_latency[%0d] got=%0d exp=3", i, lat); end
        end
    endtask

    task automatic test_byte_access;
        vec_t v[5] = '{
            '{1'b1, F3_W,  32'h20, 32'h00000000, 32'h0,        1'b0},
            '{1'b1, F3_B,  32'h21, 32'hAAAAAA80, 32'h0,        1'b0},
            '{1'b0, F3_B,  32'h21, 32'h0,        32'hFFFFFF80, 1'b0},
            '{1'b0, F3_BU, 32'h21, 32'h0,        32'h00000080, 1'b0},
            '{1'b0, F3_W,  32'h20, 32'h0,        32'h00008000, 1'b0}
        };
        logic [31:0] rd; logic er; int lat, ac;
        for (int i = 0; i < 5; i++) begin
            doTxn(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat, ac);
            checks++; if (rd !== v[i].expData || er !== v[i].expErr) begin failures++; $display("[TB] FAIL byte[%0d] got rdata=%h err=%b exp rdata=%h err=%b", i, rd, er, v[i].expData, v[i].expErr); end
        end
    endtask

    task automatic test_half_access;
        vec_t v[6] = '{
            '{1'b1, F3_H,  32'h32, 32'hFFFF1234, 32'h0,        1'b0},
            '{1'b0, F3_H,  32'h32, 32'h0,        32'h00001234, 1'b0},
            '{1'b1, F3_H,  32'h30, 32'h00008001, 32'h0,        1'b0},
            '{1'b0, F3_H,  32'h30, 32'h0,        32'hFFFF8001, 1'b0},
            '{1'b0, F3_HU, 32'h30, 32'h0,        32'h00008001, 1'b0},
            '{1'b0, F3_W,  32'h30, 32'h0,        32'h12348001, 1'b0}
        };
        logic [31:0] rd; logic er; int lat, ac;
        for (int i = 0; i < 6; i++) begin
            doTxn(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat, ac);
            checks++; if (rd !== v[i].expData || er !== v[i].expErr) begin failures++; $display("[TB] FAIL half[%0d] got rdata=%h err=%b exp rdata=%h err=%b", i, rd, er, v[i].expData, v[i].expErr); end
        end
    endtask

    task automatic test_errors;
        vec_t v[11] = '{
            '{1'b0, F3_W,   32'h13,       32'h0,        32'h0,        1'b1},
            '{1'b0, F3_H,   32'h31,       32'h0,        32'h0,        1'b1},
            '{1'b1, F3_W,   32'h1000,     32'h99999999, 32'h0,        1'b1},
            '{1'b1, 3'b100, 32'h10,       32'h00000011, 32'h0,        1'b1},
            '{1'b0, 3'b111, 32'h10,       32'h0,        32'h0,        1'b1},
            '{1'b1, F3_H,   32'h11,       32'h00007777, 32'h0,        1'b1},
            '{1'b0, F3_B,   32'h1000,     32'h0,        32'h0,        1'b1},
            '{1'b0, F3_W,   32'hFFFFFFFC, 32'h0,        32'h0,        1'b1},
            '{1'b0, F3_W,   32'h10,       32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b0, F3_W,   32'h0,        32'h0,        32'h0BADF00D, 1'b0},
            '{1'b0, F3_W,   32'h30,       32'h0,        32'h12348001, 1'b0}
        };
        logic [31:0] rd; logic er; int lat, ac;
        for (int i = 0; i < 11; i++) begin
            doTxn(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat, ac);
            checks++; if (rd !== v[i].expData || er !== v[i].expErr) begin failures++; $display("[TB] FAIL error_case[%0d] got rdata=%h err=%b exp rdata=%h err=%b", i, rd, er, v[i].expData, v[i].expErr); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic er; int lat, ac, waitCnt;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
        tick;
        req_valid = 1'b0;
        waitCnt = 0;
        while (!rsp_valid && waitCnt < 40) begin tick; waitCnt++; end
        // A competing store is offered while the response is stalled.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL backpressure[%0d] got valid=%b rdata=%h err=%b ready=%b exp valid=1 rdata=deadbeef err=0 ready=0", i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
            tick;
        end
        req_valid = 1'b0; req_we = 1'b0;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL backpressure_release got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready); end
        doTxn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat, ac);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL backpressure_no_accept got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd1, rd2; logic er; int lat, ac1, ac2;
        doTxn(1'b0, F3_W, 32'h10, 32'h0, rd1, er, lat, ac1);
        doTxn(1'b0, F3_W, 32'h30, 32'h0, rd2, er, lat, ac2);
        checks++; if (ac2 - ac1 != 4) begin failures++; $display("[TB] FAIL b2b_spacing got=%0d exp=4", ac2 - ac1); end
        checks++; if (rd1 !== 32'hDEADBEEF || rd2 !== 32'h12348001) begin failures++; $display("[TB] FAIL b2b_data got=%h,%h exp=deadbeef,12348001", rd1, rd2); end
    endtask

    task automatic test_mid_reset;
        logic [31:0] rd; logic er; int lat, ac;
        doTxn(1'b1, F3_W, 32'h40, 32'hA5A5A5A5, rd, er, lat, ac);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'h00000055;
        tick;
        req_valid = 1'b0; req_we = 1'b0;
        tick;
        // Reset lands exactly on the edge that would have performed the write.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_reset[%0d] got valid=%b ready=%b rdata=%h err=%b exp valid=0 ready=1 rdata=0 err=0", i, rsp_valid, req_ready, rsp_rdata, rsp_err);
            end
        end
        rst = 1'b1;
        tick;
        doTxn(1'b0, F3_W, 32'h40, 32'h0, rd, er, lat, ac);
        checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_old_value got rdata=%h err=%b exp rdata=a5a5a5a5 err=0", rd, er); end
    endtask

    task automatic test_zero_wait;
        vec_t v[5] = '{
            '{1'b1, F3_W,  32'h08, 32'h13579BDF, 32'h0,        1'b0},
            '{1'b0, F3_W,  32'h08, 32'h0,        32'h13579BDF, 1'b0},
            '{1'b0, F3_H,  32'h08, 32'h0,        32'hFFFF9BDF, 1'b0},
            '{1'b0, F3_BU, 32'h0B, 32'h0,        32'h00000013, 1'b0},
            '{1'b0, F3_W,  32'h09, 32'h0,        32'h0,        1'b1}
        };
        logic validNext, validAfter, er;
        logic [31:0] rd;
        for (int i = 0; i < 5; i++) begin
            zReqValid = 1'b1; zReqWe = v[i].we; zReqF3 = v[i].f3;
            zReqAddr = v[i].addr; zReqWdata = v[i].wdata;
            tick;
            zReqValid = 1'b0;
            validNext = zRspValid; rd = zRspRdata; er = zRspErr;
            zRspReady = 1'b1;
            tick;
            zRspReady = 1'b0;
            validAfter = zRspValid;
            checks++; if (validNext !== 1'b1 || validAfter !== 1'b0) begin failures++; $display("[TB] FAIL zero_wait_timing[%0d] got first=%b after=%b exp first=1 after=0", i, validNext, validAfter); end
            checks++; if (rd !== v[i].expData || er !== v[i].expErr) begin failures++; $display("[TB] FAIL zero_wait_data[%0d] got rdata=%h err=%b exp rdata=%h err=%b", i, rd, er, v[i].expData, v[i].expErr); end
        end
    endtask

    initial begin
        test_reset;
        test_word_access;
        test_byte_access;
        test_half_access;
        test_errors;
        test_backpressure;
        test_back_to_back;
        test_mid_reset;
        test_zero_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence above never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got no completion, required finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's load/store data bus: accepts one request at a time from the core's memory-access stage.
- Serves each request from an internal word-organised RAM, with a configurable number of wait states.
- Returns load data aligned and sign/zero-extended according to the RV32I funct3 width encoding.
- Reports misaligned, out-of-range and illegal-width accesses as errors instead of performing them.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words (power of two, ≥4).
- WAIT_CYCLES, 2, wait states between request accept and response (0–15).
- ADDR_BASE, 32'h0000_0000, byte address of RAM word 0 (word-aligned).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  access width: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, taken from the low bits according to the width.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load result, extended per funct3; 0 for stores and for errors.
- rsp_err  output  1  the request was rejected.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state = IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter = 0.
  - RAM contents are not cleared.
  - Reset mid-operation drops the pending request; a store still in WAIT is never written.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1, capture we, funct3, addr and wdata.
    - WAIT_CYCLES=0: go directly to RESP.
    - Otherwise: go to WAIT with counter = WAIT_CYCLES−1.
  - WAIT: req_ready=0. Decrement the counter each cycle; at 0, go to RESP on the next edge.
  - RESP: rsp_valid=1, rsp_rdata and rsp_err stable, req_ready=0.
    - On rsp_ready=1, go to IDLE. rsp_valid drops the cycle after acceptance.
    - rsp_ready may already be high on the first RESP cycle; the response then completes in one cycle.
- Latency: accept edge to first rsp_valid cycle = WAIT_CYCLES+1 cycles. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Error check, evaluated on the captured request:
  - Illegal width: funct3 ∈ {011, 110, 111}, or a store with funct3 ∈ {100, 101}.
  - Misaligned: a halfword with addr[0]=1, or a word with addr[1:0]≠0.
  - Out of range: offset = addr−ADDR_BASE (32-bit unsigned) ≥ DEPTH_WORDS×4. An address below the base wraps to a large offset and is therefore out of range.
  - On any error: rsp_err=1, rsp_rdata=0, no RAM write.
- RAM access happens on the WAIT→RESP (or IDLE→RESP) transition edge:
  - Index = offset[log2(DEPTH_WORDS)+1:2]; byte lane = offset[1:0].
  - Store: byte-enable writes. SB writes lane offset[1:0] with wdata[7:0]. SH writes lanes {1,0} or {3,2} with wdata[15:0]. SW writes all four lanes.
  - Load: the selected byte or half is shifted to bit 0. B and H sign-extend; BU and HU zero-extend; W is passed through.
  - rsp_rdata is registered; a store response returns rsp_rdata=0, rsp_err=0.
- Ordering: a load issued after a store's response has been accepted returns the stored data; there is no forwarding hazard.
- Inputs are ignored outside IDLE. req_valid held high during a busy phase is not accepted until the next IDLE cycle.
- rsp_valid never deasserts without rsp_ready. No X may appear on outputs after reset.

Decomposition:
- Shared package (mem_pkg):
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum {IDLE, WAIT, RESP}.
  - Helper function for load extension, which the core's load path can reuse.
- Sub-module byte_lane_ram:
  - DEPTH_WORDS×32 array with 4-bit byte-enable write and synchronous read.
  - One read/write port, registered read, no reset.
  - Instantiated once by data_mem_responder, which keeps the FSM, error check and extension logic.

Test Plan:
- After reset, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid first high exactly 3 cycles after each accept (WAIT_CYCLES=2).
- SB addr 0x21 data 0x80, then LB 0x21 → 0xFFFFFF80; LBU 0x21 → 0x00000080; LW 0x20 shows 0x80 only in byte 1.
- SH 0x32 data 0x1234, then LH 0x32 → 0x00001234; SH 0x30 data 0x8001, then LH 0x30 → 0xFFFF8001; LW 0x30 → 0x12348001.
- Errors each give rsp_err=1, rsp_rdata=0, with the previously stored word unchanged:
  - LW 0x13 (misaligned).
  - LH 0x31 (misaligned).
  - SW 0x1000 with DEPTH_WORDS=1024 (out of range).
  - Store with funct3=100 (illegal width).
  - Load with funct3=111 (illegal width).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0; a new req_valid during this time is not accepted.
- Mid-operation reset: SW 0x40 data 0x55, assert rst=0 during WAIT, release, then LW 0x40 → old value (0x0 if preloaded) and rsp_valid=0 throughout reset. Separately, with WAIT_CYCLES=0 → response on the cycle after accept.
